// File: rtl/spi_target_if.sv
// Bus bundle for spi_target: SPI pins plus the byte-wide transmit/receive handshakes.
// The slave modport is the target engine's view; master is the controller/fabric view.
interface spi_target_if;
  logic       spi_ss_n;
  logic       spi_sck;
  logic       spi_sdi;
  logic       spi_sdo;
  logic       spi_sdo_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       busy;

  modport slave (
    input  spi_ss_n,
    input  spi_sck,
    input  spi_sdi,
    input  tx_data,
    input  tx_valid,
    input  rx_ack,
    output spi_sdo,
    output spi_sdo_en,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output rx_overrun,
    output busy
  );

  modport master (
    output spi_ss_n,
    output spi_sck,
    output spi_sdi,
    output tx_data,
    output tx_valid,
    output rx_ack,
    input  spi_sdo,
    input  spi_sdo_en,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_overrun,
    input  busy
  );
endinterface

// File: rtl/spi_target.sv
// SPI target engine, mode 0, MSB first. SPI pins are oversampled in the CLK1 domain;
// one-byte transmit holding register and a receive register with valid/ack handshakes.
module spi_target #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic        CLK1,
  input  logic        RESET,
  spi_target_if.slave bus
);

  typedef enum logic {StIdle, StShift} state_e;

  // Synchronisers: 2 flops plus a history flop for edge detection.
  logic       ss_meta_q, ss_sync_q, ss_hist_q;
  logic       sck_meta_q, sck_sync_q, sck_hist_q;
  logic       sdi_meta_q, sdi_sync_q;
  // Marks which synchroniser stages hold real samples rather than reset values.
  logic [2:0] vld_q;

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      ss_meta_q  <= 1'b1;
      ss_sync_q  <= 1'b1;
      ss_hist_q  <= 1'b1;
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_hist_q <= 1'b0;
      sdi_meta_q <= 1'b0;
      sdi_sync_q <= 1'b0;
      vld_q      <= 3'b000;
    end else begin
      ss_meta_q  <= bus.spi_ss_n;
      ss_sync_q  <= ss_meta_q;
      ss_hist_q  <= ss_sync_q;
      sck_meta_q <= bus.spi_sck;
      sck_sync_q <= sck_meta_q;
      sck_hist_q <= sck_sync_q;
      sdi_meta_q <= bus.spi_sdi;
      sdi_sync_q <= sdi_meta_q;
      vld_q      <= {vld_q[1:0], 1'b1};
    end
  end

  logic ss_fall, ss_rise, sck_rise, sck_fall;
  assign ss_fall  = ss_hist_q & ~ss_sync_q;
  assign ss_rise  = ~ss_hist_q & ss_sync_q;
  assign sck_rise = ~sck_hist_q & sck_sync_q;
  assign sck_fall = sck_hist_q & ~sck_sync_q;

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [6:0] tx_sr_q, tx_sr_d;
  logic       sdo_q, sdo_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic [7:0] next_byte;

  assign next_byte = tx_full_q ? tx_hold_q : FILL;

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      cnt_q        <= 3'd0;
      rx_sr_q      <= 7'd0;
      tx_sr_q      <= 7'd0;
      sdo_q        <= 1'b1;
      tx_hold_q    <= 8'd0;
      tx_full_q    <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      sdo_q        <= sdo_d;
      tx_hold_q    <= tx_hold_d;
      tx_full_q    <= tx_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    sdo_d        = sdo_q;
    tx_hold_d    = tx_hold_q;
    tx_full_d    = tx_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;

    // A select only counts once SS has been seen genuinely high after reset.
    if (vld_q[2] && ss_hist_q) begin
      armed_d = 1'b1;
    end

    if (bus.rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (ss_fall && armed_q) begin
          state_d   = StShift;
          cnt_d     = 3'd0;
          tx_sr_d   = next_byte[6:0];
          sdo_d     = next_byte[7];
          tx_full_d = 1'b0;
        end
      end
      StShift: begin
        if (ss_rise) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else if (sck_rise) begin
          rx_sr_d = {rx_sr_q[5:0], sdi_sync_q};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = {rx_sr_q, sdi_sync_q};
            rx_valid_d = 1'b1;
            // A same-cycle ack consumed the old byte, so that is not an overrun.
            if (rx_valid_q && !bus.rx_ack) begin
              rx_overrun_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (cnt_q != 3'd0) begin
            sdo_d   = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end else begin
            tx_sr_d   = next_byte[6:0];
            sdo_d     = next_byte[7];
            tx_full_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Only accepted while empty, so it can never collide with a load above.
    if (bus.tx_valid && !tx_full_q) begin
      tx_hold_d = bus.tx_data;
      tx_full_d = 1'b1;
    end
  end

  assign bus.spi_sdo    = sdo_q;
  assign bus.spi_sdo_en = (state_q == StShift);
  assign bus.tx_ready   = ~tx_full_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.busy       = (state_q == StShift) && (cnt_q != 3'd0);

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) engine, mode 0, MSB first: the responding end of the SPI links that the fpga20 core drives as controller. It lets an external SPI controller on the I/O-board header exchange bytes with logic inside the FPGA. All SPI inputs are oversampled and synchronised into the `CLK1` domain, with no logic clocked by SCK. The bus side gets a one-byte transmit holding register and a receive register with valid/ack handshakes.

## Interface

- `FILL`, 8'hFF: byte shifted out when no transmit byte is pending at byte start.
- `CLK1`  in  1  system clock; every register is in this domain.
- `RESET`  in  1  asynchronous, active-high reset.
- `spi_ss_n`  in  1  target select from the external controller, active low, asynchronous.
- `spi_sck`  in  1  serial clock from the controller, asynchronous, idle low.
- `spi_sdi`  in  1  controller-to-target data (MOSI), asynchronous.
- `spi_sdo`  out  1  target-to-controller data (MISO).
- `spi_sdo_en`  out  1  high while selected; top level tri-states `spi_sdo` when low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  transmit holding register empty.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` unread.
- `rx_ack`  in  1  consume `rx_data`.
- `rx_overrun`  out  1  sticky flag: a byte completed while `rx_valid` was already high.
- `busy`  out  1  selected and a byte is partially shifted.

## Operation

- **Synchroniser.** `spi_ss_n`, `spi_sck` and `spi_sdi` each pass through a 2-flop synchroniser, then 1 history flop. Edges are detected on the synchronised values.
- **States.**
  - IDLE: SS deasserted. Moves to SHIFT on the SS falling edge.
  - SHIFT: selected. Moves back to IDLE on the SS rising edge from any bit position.
- **SS falling edge.**
  - Load the shift-out register from the holding register and mark it empty. If the holding register is empty, load `FILL` instead.
  - Set bit count to 0 and drive `spi_sdo` = bit 7.
- **SCK rising edge (SHIFT).**
  - Shift synchronised SDI into the receive shift register, LSB end.
  - Increment bit count (3 bits, wraps 7→0).
  - On the edge that takes the count from 7 to 0:
    - `rx_data` takes the completed byte.
    - If `rx_valid` is already high, set `rx_overrun`.
    - `rx_valid` goes high.
- **SCK falling edge (SHIFT).**
  - Count ≠ 0: shift out the next bit.
  - Count = 0 (byte boundary): reload the shift-out register from the holding register (or `FILL`) and drive bit 7.
- **SS rising edge.** Discard the partial receive byte: no `rx_valid`, count goes to 0. A byte already moved into the shift-out register is lost; the holding register is unaffected.
- **SCK edges while deselected** are ignored.
- **Transmit handshake.**
  - `tx_valid & tx_ready` writes the holding register.
  - `tx_ready` falls the next cycle.
  - `tx_ready` rises the cycle after the holding register is loaded into the shift register.
- **Receive handshake.**
  - `rx_ack` clears `rx_valid` and `rx_overrun` the next cycle.
  - If a byte completes in the same cycle as `rx_ack`, the completion wins: `rx_valid` stays 1 and `rx_overrun` is not set.
- **`busy`.** Selected and count ≠ 0.
- **Reset values.**
  - State IDLE; count 0; shift registers 0.
  - `spi_sdo` = 1, `spi_sdo_en` = 0.
  - `tx_ready` = 1, `rx_valid` = 0, `rx_overrun` = 0, `rx_data` = 0, `busy` = 0.
  - Synchroniser flops reset to idle levels: SS=1, SCK=0, SDI=0.
- **Reset mid-transfer.** Abort immediately; the byte is lost. After reset, the engine waits for a fresh SS falling edge, even if SS is already low.

## Timing

- SCK high and low phases must each be ≥ 4 `CLK1` periods, so f_SCK ≤ f_CLK1/8.
- SS falling to SCK first rising edge: ≥ 4 `CLK1` periods.
- SDI is sampled 3 `CLK1` cycles after the physical SCK rising edge (2 sync + 1 edge-detect). The controller must hold SDI stable for that long.
- `spi_sdo` changes 3 `CLK1` cycles after the physical SCK falling edge or SS falling edge.
- `spi_sdo_en` follows synchronised SS, with 3 cycles of latency.
- `rx_valid` rises 1 `CLK1` cycle after the 8th detected SCK rising edge.

## Test plan

- **Single byte.**
  - Preload `tx_data`=8'hA5; controller sends 8'h3C at CLK1/8.
  - Required: MISO bits 1,0,1,0,0,1,0,1; `rx_data`=8'h3C; `rx_valid` high; `tx_ready` high again after SS falls.
- **Underrun.**
  - No tx byte loaded; 2-byte transfer.
  - Required: MISO returns 8'hFF, 8'hFF.
  - Override `FILL`=8'h00 and repeat: required 8'h00, 8'h00.
- **Back-to-back with reload.**
  - Load 8'h11, then 8'h22 during byte 1; controller sends 8'h01, 8'h02 under one SS.
  - Required: MISO 8'h11, 8'h22; two `rx_valid` events acked in turn; no overrun.
- **Overrun.**
  - Two bytes 8'hAA, 8'h55 with no `rx_ack`.
  - Required: `rx_data`=8'h55, `rx_overrun`=1.
  - `rx_ack` clears both flags next cycle.
- **Abort.**
  - SS rises after 5 SCK edges.
  - Required: no `rx_valid`, `busy` drops, `spi_sdo_en`=0.
  - Next full byte 8'hC3 is received correctly.
- **Reset mid-byte.**
  - `RESET` pulse after bit 3 with SS still low.
  - Required: all outputs at reset values; SCK edges ignored until SS toggles high→low.
